// File: rtl/uart_frame_encoder.sv
// uart_frame_encoder: frames four 8-bit game channels as {header, payload} bytes into the UART TX FIFO.
// Build macro UART_TX_CHECKSUM_EN appends a (header ^ payload) check byte to every frame.
module uart_frame_encoder #(
   parameter int         HEARTBEAT_CYCLES = 6_500_000,
   parameter logic [3:0] SYNC_NIBBLE      = 4'hA
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_game_state_sel,
   input  logic [7:0] data_gloves_control,
   input  logic [7:0] data_mouse_control,
   input  logic [7:0] data_score_control,
   input  logic       tx_full,
   output logic [7:0] w_data,
   output logic       wr_uart,
   output logic       busy,
   output logic [2:0] fsm_state
);

   localparam int HB_W = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
   localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HDR   = 3'd1,
      GAP1  = 3'd2,
      PAY   = 3'd3,
      GAP1B = 3'd4,
      CHK   = 3'd5,
      GAP2  = 3'd6
   } state_t;

   state_t          state_q, state_n;
   logic [7:0]      w_data_n;
   logic            wr_n;
   logic            busy_n;

   logic [7:0]      data [4];
   logic [7:0]      last_sent [4];
   logic [3:0]      dirty_q, dirty_n, dirty_set, dirty_clr;
   logic [1:0]      rr_q;
   logic [1:0]      ch_q;
   logic [7:0]      pay_q;
   logic [HB_W-1:0] hb_cnt;
   logic            hb_tick;

   logic            grant;
   logic            grant_found;
   logic [1:0]      grant_ch;
   logic [1:0]      cand;
   logic [7:0]      header;

   assign data[0]   = data_game_state_sel;
   assign data[1]   = data_gloves_control;
   assign data[2]   = data_mouse_control;
   assign data[3]   = data_score_control;
   assign hb_tick   = (hb_cnt == HB_LAST);
   assign header    = {SYNC_NIBBLE, 2'b00, ch_q};
   assign fsm_state = state_q;

   // Round-robin pick: first dirty channel at or after rr_q, wrapping mod 4.
   always_comb begin
      grant_found = 1'b0;
      grant_ch    = rr_q;
      cand        = rr_q;
      for (int i = 0; i < 4; i++) begin
         cand = rr_q + 2'(i);
         if (!grant_found && dirty_q[cand]) begin
            grant_found = 1'b1;
            grant_ch    = cand;
         end
      end
   end

   always_comb begin
      state_n  = state_q;
      w_data_n = w_data;
      wr_n     = 1'b0;
      busy_n   = busy;
      grant    = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_found) begin
               grant   = 1'b1;
               busy_n  = 1'b1;
               state_n = HDR;
            end
         end
         HDR: begin
            if (!tx_full) begin
               w_data_n = header;
               wr_n     = 1'b1;
               state_n  = GAP1;
            end
         end
         GAP1: state_n = PAY;
         PAY: begin
            if (!tx_full) begin
               w_data_n = pay_q;
               wr_n     = 1'b1;
`ifdef UART_TX_CHECKSUM_EN
               state_n  = GAP1B;
`else
               state_n  = GAP2;
`endif
            end
         end
`ifdef UART_TX_CHECKSUM_EN
         GAP1B: state_n = CHK;
         CHK: begin
            if (!tx_full) begin
               w_data_n = header ^ pay_q;
               wr_n     = 1'b1;
               state_n  = GAP2;
            end
         end
`endif
         GAP2: begin
            busy_n  = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // The granted channel compares against the value being snapshotted now, so it only
   // re-dirties on a heartbeat; a later input change still differs from the snapshot.
   always_comb begin
      dirty_set = '0;
      dirty_clr = '0;
      for (int i = 0; i < 4; i++) begin
         dirty_clr[i] = grant && (grant_ch == 2'(i));
         dirty_set[i] = hb_tick || (!dirty_clr[i] && (data[i] != last_sent[i]));
      end
      dirty_n = (dirty_q & ~dirty_clr) | dirty_set;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         w_data  <= '0;
         wr_uart <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_n;
         w_data  <= w_data_n;
         wr_uart <= wr_n;
         busy    <= busy_n;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            last_sent[i] <= '0;
         end
         dirty_q <= 4'b1111;
         rr_q    <= '0;
         ch_q    <= '0;
         pay_q   <= '0;
         hb_cnt  <= '0;
      end else begin
         dirty_q <= dirty_n;
         hb_cnt  <= hb_tick ? '0 : hb_cnt + HB_W'(1);
         if (grant) begin
            ch_q                <= grant_ch;
            pay_q               <= data[grant_ch];
            last_sent[grant_ch] <= data[grant_ch];
            rr_q                <= grant_ch + 2'd1;
         end
      end
   end

endmodule
